// File: rtl/rsa_pkg.sv
// Shared RSA datapath definitions: FSM state encodings and width helpers.
package rsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_SCAN,
    ST_SQR,
    ST_MUL,
    ST_OUT
  } modexp_v2_state_t;

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_RUN,
    MM_DONE
  } modmult_state_t;

  // Width of the modmult operation counter for a given exponent width.
  function automatic int calc_cnt_w(input int exp_width);
    return $clog2(2 * exp_width + 2);
  endfunction

  // Width of the exponent bit-position down-counter (at least one bit).
  function automatic int calc_bp_w(input int exp_width);
    return (exp_width > 1) ? $clog2(exp_width) : 1;
  endfunction

endpackage

// File: rtl/modmult.sv
// Bit-serial interleaved modular multiplier: result = a*b mod n.
// Requires b <= n and n != 0. One bit of a (MSB first) per cycle.
// Handshake: go is held high with stable operands until done is seen;
// dropping go at any time returns the unit to idle.
module modmult
  import rsa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int STEP_W = $clog2(WIDTH + 1);

  modmult_state_t    state, state_next;
  logic [WIDTH-1:0]  a_r, b_r, n_r, r;
  logic [STEP_W-1:0] steps;

  logic [WIDTH:0]    dbl;
  logic [WIDTH-1:0]  dbl_red;
  logic [WIDTH:0]    sum;
  logic [WIDTH-1:0]  r_next;

  // One interleaved step: r = 2r mod n, then add b when the current bit of a is set.
  always_comb begin
    dbl     = {r, 1'b0};
    dbl_red = (dbl >= {1'b0, n_r}) ? (dbl[WIDTH-1:0] - n_r) : dbl[WIDTH-1:0];
    sum     = a_r[WIDTH-1] ? ({1'b0, dbl_red} + {1'b0, b_r}) : {1'b0, dbl_red};
    r_next  = (sum >= {1'b0, n_r}) ? (sum[WIDTH-1:0] - n_r) : sum[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MM_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; losing go abandons the multiplication.
  always_comb begin
    state_next = state;
    case (state)
      MM_IDLE: if (go) state_next = MM_RUN;
      MM_RUN: begin
        if (!go)                          state_next = MM_IDLE;
        else if (steps == STEP_W'(1))     state_next = MM_DONE;
      end
      MM_DONE: if (!go) state_next = MM_IDLE;
      default: state_next = MM_IDLE;
    endcase
  end

  // Outputs: done only while parked in DONE.
  always_comb begin
    done   = (state == MM_DONE);
    result = r;
  end

  // Operand capture and per-bit accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      n_r   <= '0;
      r     <= '0;
      steps <= '0;
    end else begin
      case (state)
        MM_IDLE: begin
          if (go) begin
            a_r   <= a;
            b_r   <= b;
            n_r   <= n;
            r     <= '0;
            steps <= STEP_W'(WIDTH);
          end
        end
        MM_RUN: begin
          if (go) begin
            r     <= r_next;
            a_r   <= a_r << 1;
            steps <= steps - STEP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/modexp_v2.sv
// Modular exponentiation result = m^e mod n, left-to-right square-and-multiply
// on a single shared modmult. Request handshake: a transfer happens on a rising
// edge where valid && ready are both high, on both the in_* and out_* sides;
// out_valid, result, err and op_count hold stable until accepted.
module modexp_v2
  import rsa_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = WIDTH,
  localparam int CNT_W    = calc_cnt_w(EXP_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     m,
  input  logic [EXP_WIDTH-1:0] e,
  input  logic [WIDTH-1:0]     n,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 err,
  output logic [CNT_W-1:0]     op_count,
  output logic                 busy
);

  localparam int BP_W = calc_bp_w(EXP_WIDTH);

  modexp_v2_state_t     state, state_next;
  logic [WIDTH-1:0]     m_r, n_r, base, acc;
  logic [EXP_WIDTH-1:0] e_r;
  logic [BP_W-1:0]      bitpos;
  logic [CNT_W-1:0]     cnt;

  logic                 mm_go, mm_done;
  logic [WIDTH-1:0]     mm_a, mm_b, mm_result;

  logic accept, mult_state, mm_cap, cur_bit, last_bit;

  assign accept     = in_valid && (state == ST_IDLE);
  assign mult_state = (state == ST_REDUCE) || (state == ST_SQR) || (state == ST_MUL);
  assign mm_cap     = mm_go && mm_done && !abort;
  assign cur_bit    = e_r[bitpos];
  assign last_bit   = (bitpos == '0);

  // Operand selection for the shared multiplier; the reduce step computes m*1 mod n.
  always_comb begin
    mm_a = acc;
    mm_b = base;
    case (state)
      ST_REDUCE: begin
        mm_a = m_r;
        mm_b = WIDTH'(1);
      end
      ST_SQR: mm_b = acc;
      default: ;
    endcase
  end

  modmult #(.WIDTH(WIDTH)) u_modmult (
    .clk    (clk),
    .rst    (rst),
    .go     (mm_go),
    .a      (mm_a),
    .b      (mm_b),
    .n      (n_r),
    .result (mm_result),
    .done   (mm_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; abort cancels any working state, never IDLE or OUT.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (n == '0 || e == '0) state_next = ST_OUT;
          else                    state_next = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        if (abort)       state_next = ST_IDLE;
        else if (mm_cap) state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (abort)        state_next = ST_IDLE;
        else if (cur_bit) state_next = last_bit ? ST_OUT : ST_SQR;
      end
      ST_SQR: begin
        if (abort)        state_next = ST_IDLE;
        else if (mm_cap) begin
          if (cur_bit)       state_next = ST_MUL;
          else if (last_bit) state_next = ST_OUT;
        end
      end
      ST_MUL: begin
        if (abort)       state_next = ST_IDLE;
        else if (mm_cap) state_next = last_bit ? ST_OUT : ST_SQR;
      end
      ST_OUT: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    in_ready  = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    out_valid = (state == ST_OUT);
  end

  // Datapath: request capture, multiplier issue/capture, bit walk and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_r      <= '0;
      e_r      <= '0;
      n_r      <= '0;
      base     <= '0;
      acc      <= '0;
      bitpos   <= '0;
      cnt      <= '0;
      mm_go    <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
      op_count <= '0;
    end else begin
      // go rises one cycle after entering a multiply state and falls once done is captured,
      // which guarantees at least one low cycle between consecutive issues.
      if (mult_state && !abort) mm_go <= !(mm_go && mm_done);
      else                      mm_go <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            m_r <= m;
            e_r <= e;
            n_r <= n;
            cnt <= '0;
            if (n == '0) begin
              result   <= '0;
              err      <= 1'b1;
              op_count <= '0;
            end else if (e == '0) begin
              result   <= (n == WIDTH'(1)) ? '0 : WIDTH'(1);
              err      <= 1'b0;
              op_count <= '0;
            end
          end
        end
        ST_REDUCE: begin
          if (mm_cap) begin
            base   <= mm_result;
            cnt    <= cnt + CNT_W'(1);
            bitpos <= BP_W'(EXP_WIDTH - 1);
          end
        end
        ST_SCAN: begin
          if (!abort) begin
            if (cur_bit) begin
              acc <= base;
              if (last_bit) begin
                result   <= base;
                err      <= 1'b0;
                op_count <= cnt;
              end else begin
                bitpos <= bitpos - BP_W'(1);
              end
            end else begin
              bitpos <= bitpos - BP_W'(1);
            end
          end
        end
        ST_SQR: begin
          if (mm_cap) begin
            acc <= mm_result;
            cnt <= cnt + CNT_W'(1);
            if (!cur_bit) begin
              if (last_bit) begin
                result   <= mm_result;
                err      <= 1'b0;
                op_count <= cnt + CNT_W'(1);
              end else begin
                bitpos <= bitpos - BP_W'(1);
              end
            end
          end
        end
        ST_MUL: begin
          if (mm_cap) begin
            acc <= mm_result;
            cnt <= cnt + CNT_W'(1);
            if (last_bit) begin
              result   <= mm_result;
              err      <= 1'b0;
              op_count <= cnt + CNT_W'(1);
            end else begin
              bitpos <= bitpos - BP_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
